// File: rtl/serial_fa_ctrl_if.sv
// serial_fa_ctrl_if: host-side start/busy/done handshake and operand/result bus.
// ovf is present only when SERIAL_FA_OVF_EN is defined.
interface serial_fa_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_FA_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/serial_fa_ctrl.sv
// serial_fa_ctrl: bit-serial adder, one FA cell (two half adders), LSB first.
// Define SERIAL_FA_OVF_EN to add the two's-complement overflow output ovf.
module serial_fa_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_fa_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cout_q;
  logic             accept;
  logic             last;
  logic             h1_s;
  logic             h1_c;
  logic             fa_s;
  logic             fa_c;
`ifdef SERIAL_FA_OVF_EN
  logic             ovf_q;
`endif

  assign accept = (state == IDLE) && bus.start;
  assign last   = (cnt == CW'(WIDTH - 1));

  // full adder built from two half adders
  always_comb begin
    h1_s = a_sr[0] ^ b_sr[0];
    h1_c = a_sr[0] & b_sr[0];
    fa_s = h1_s ^ carry;
    fa_c = h1_c | (h1_s & carry);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (bus.start) nxt = RUN;
      RUN:     if (last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      acc    <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
`ifdef SERIAL_FA_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= bus.a;
      b_sr  <= bus.b;
      carry <= bus.cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      acc   <= {fa_s, acc[WIDTH-1:1]};
      carry <= fa_c;
      cnt   <= cnt + CW'(1);
      // visible result only moves on the final bit
      if (last) begin
        sum_q  <= {fa_s, acc[WIDTH-1:1]};
        cout_q <= fa_c;
`ifdef SERIAL_FA_OVF_EN
        ovf_q  <= carry ^ fa_c;
`endif
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_FA_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_fa_ctrl.sv
// tb_serial_fa_ctrl: random and directed checks of serial_fa_ctrl
// at WIDTH=8 and an exhaustive WIDTH=2 sweep.
module tb_serial_fa_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  serial_fa_ctrl_if #(.WIDTH(8)) m8 ();
  serial_fa_ctrl_if #(.WIDTH(2)) m2 ();

  serial_fa_ctrl #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (m8)
  );

  serial_fa_ctrl #(.WIDTH(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (m2)
  );

  always #5 clk = ~clk;

  // returns {ovf, cout, sum} from plain arithmetic
  function automatic logic [9:0] ref8(input logic [7:0] a, b,
                                      input logic c);
    logic [8:0] t;
    logic       ov;
    t  = {1'b0, a} + {1'b0, b} + 9'(c);
    ov = (a[7] == b[7]) && (t[7] != a[7]);
    return {ov, t};
  endfunction

  task automatic add8(input string nm, input logic [7:0] a, b,
                      input logic c, input bit poke);
    logic [9:0] exp;
    logic [7:0] ps;
    logic       pc;
    int         lat;
    int         bcnt;
    int         dcnt;
    bit         held;
    exp = ref8(a, b, c);
    @(negedge clk);
    ps = m8.sum;
    pc = m8.cout;
    m8.a = a;
    m8.b = b;
    m8.cin = c;
    m8.start = 1'b1;
    @(negedge clk);
    m8.start = 1'b0;
    m8.a = 8'($urandom);
    m8.b = 8'($urandom);
    m8.cin = 1'($urandom);
    lat = 0;
    bcnt = 0;
    held = 1'b1;
    while (!m8.done && lat < 40) begin
      if (m8.busy) bcnt++;
      if (m8.sum !== ps || m8.cout !== pc) held = 1'b0;
      @(negedge clk);
      lat++;
      m8.start = poke && (lat == 2 || lat == 5);
      if (m8.start) begin
        m8.a = 8'($urandom);
        m8.b = 8'($urandom);
      end
    end
    m8.start = 1'b0;
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL %s_latency: got %0d exp 8", nm, lat);
    end
    checks++;
    if (bcnt !== 8) begin
      errors++;
      $display("FAIL %s_busy: got %0d cycles exp 8", nm, bcnt);
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL %s_hold: sum/cout moved during run, got 0 exp 1", nm);
    end
    checks++;
    if ({m8.cout, m8.sum} !== exp[8:0]) begin
      errors++;
      $display("FAIL %s_result: got %h exp %h", nm, {m8.cout, m8.sum}, exp[8:0]);
    end
`ifdef SERIAL_FA_OVF_EN
    checks++;
    if (m8.ovf !== exp[9]) begin
      errors++;
      $display("FAIL %s_ovf: got %b exp %b", nm, m8.ovf, exp[9]);
    end
`endif
    dcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (m8.done) dcnt++;
    end
    checks++;
    if (dcnt !== 0) begin
      errors++;
      $display("FAIL %s_done_extra: got %0d exp 0", nm, dcnt);
    end
    checks++;
    if ({m8.cout, m8.sum} !== exp[8:0]) begin
      errors++;
      $display("FAIL %s_held_after: got %h exp %h", nm, {m8.cout, m8.sum}, exp[8:0]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    m8.start = 1'b0; m8.a = '0; m8.b = '0; m8.cin = 1'b0;
    m2.start = 1'b0; m2.a = '0; m2.b = '0; m2.cin = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({m8.busy, m8.done, m8.cout, m8.sum} !== 11'd0) begin
      errors++;
      $display("FAIL reset8: got %h exp 0", {m8.busy, m8.done, m8.cout, m8.sum});
    end
    checks++;
    if ({m2.busy, m2.done, m2.cout, m2.sum} !== 5'd0) begin
      errors++;
      $display("FAIL reset2: got %h exp 0", {m2.busy, m2.done, m2.cout, m2.sum});
    end
`ifdef SERIAL_FA_OVF_EN
    checks++;
    if (m8.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b exp 0", m8.ovf);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    add8("d35_4a", 8'h35, 8'h4A, 1'b0, 1'b0);
    add8("dff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    add8("d00_cin", 8'h00, 8'h00, 1'b1, 1'b0);
`ifdef SERIAL_FA_OVF_EN
    add8("d7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);
    add8("dff_ff", 8'hFF, 8'hFF, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++)
      add8("rand", 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic test_ignore_start;
    add8("poke", 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    add8("after_poke", 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic test_reset_mid;
    bit stray;
    @(negedge clk);
    m8.a = 8'($urandom_range(1, 255));
    m8.b = 8'($urandom);
    m8.cin = 1'b1;
    m8.start = 1'b1;
    @(negedge clk);
    m8.start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (m8.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy: got %b exp 1", m8.busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({m8.busy, m8.done, m8.cout, m8.sum} !== 11'd0) begin
      errors++;
      $display("FAIL midrst_clear: got %h exp 0", {m8.busy, m8.done, m8.cout, m8.sum});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stray = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (m8.done || m8.busy) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL midrst_stray: got 1 exp 0");
    end
    add8("midrst_next", 8'h10, 8'h20, 1'b0, 1'b0);
  endtask

  task automatic test_w2_sweep;
    int lat;
    int e;
    for (int i = 0; i < 32; i++) begin
      e = (i >> 3) + ((i >> 1) & 3) + (i & 1);
      @(negedge clk);
      m2.a = 2'(i >> 3);
      m2.b = 2'(i >> 1);
      m2.cin = 1'(i);
      m2.start = 1'b1;
      @(negedge clk);
      m2.start = 1'b0;
      lat = 0;
      while (!m2.done && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat !== 2 || {m2.cout, m2.sum} !== 3'(e)) begin
        errors++;
        $display("FAIL w2_case%0d: got lat %0d res %0d exp lat 2 res %0d",
                 i, lat, {m2.cout, m2.sum}, e);
      end
      @(negedge clk);
      checks++;
      if (m2.done !== 1'b0) begin
        errors++;
        $display("FAIL w2_width%0d: got done %b exp 0", i, m2.done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_w2_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
